tap_serializer: RTL and testbench

TAP_SERIALIZER -- requirements
Module: tap_serializer

---
 rtl/tap_serializer_pkg.sv | 17 +
 rtl/sat_counter.sv | 21 ++
 rtl/tap_serializer.sv | 116 +++++++++++
 tb/tb_tap_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tap_serializer_pkg.sv
// Shared types and constants for the tap serializer: FSM states, tap tags and
// the default tap width.
package tap_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] TAG_T1 = 2'd0;
  localparam logic [1:0] TAG_T2 = 2'd1;
  localparam logic [1:0] TAG_T4 = 2'd2;
  localparam logic [1:0] TAG_T7 = 2'd3;

  localparam int DATA_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clr wins over inc, and the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its inputs from before the clock edge.
  always_ff @(posedge clock) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tap_serializer.sv
// Captures four delay-line taps into a frame and emits them as tagged beats.
// Optional out_parity port is enabled by defining TAP_SERIALIZER_PARITY_EN.
module tap_serializer
  import tap_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  sample,
  input  logic [DATA_WIDTH-1:0] tap_1,
  input  logic [DATA_WIDTH-1:0] tap_2,
  input  logic [DATA_WIDTH-1:0] tap_4,
  input  logic [DATA_WIDTH-1:0] tap_7,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_tag,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
`ifdef TAP_SERIALIZER_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] frame [4];
  logic [1:0]            idx;
  logic                  capture;
  logic                  transfer;
  logic                  drop;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    transfer   = 1'b0;
    drop       = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_tag    = '0;
    unique case (state)
      IDLE: begin
        if (sample) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = frame[idx];
        out_tag   = idx;
        transfer  = out_ready;
        // The last beat leaving frees the frame, so a coincident sample
        // refills it back-to-back instead of being dropped.
        if (transfer && (idx == TAG_T7)) begin
          if (sample) begin
            capture = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (sample) begin
          drop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SEND);

  // NOTE: the frame is only four words and must read back as zero after
  // reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clock) begin
    if (rst) begin
      idx <= TAG_T1;
      for (int i = 0; i < 4; i++) begin
        frame[i] <= '0;
      end
    end else if (capture) begin
      frame[TAG_T1] <= tap_1;
      frame[TAG_T2] <= tap_2;
      frame[TAG_T4] <= tap_4;
      frame[TAG_T7] <= tap_7;
      idx           <= TAG_T1;
    end else if (transfer) begin
      idx <= idx + 2'd1;
    end
  end

  sat_counter #(
    .WIDTH(DROP_WIDTH)
  ) u_drop_counter (
    .clock(clock),
    .inc  (drop),
    .clr  (rst),
    .count(drop_count)
  );

`ifdef TAP_SERIALIZER_PARITY_EN
  assign out_parity = out_valid & (^out_data);
`endif

endmodule

// File: tb/tb_tap_serializer.sv
// Scoreboard bench for tap_serializer: a full-width instance plus a
// DROP_WIDTH=2 instance sharing the same stimulus.
module tb_tap_serializer;
  import tap_serializer_pkg::*;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          rst;
  logic          sample;
  logic          out_ready;
  logic [DW-1:0] tap_1, tap_2, tap_4, tap_7;

  logic          a_valid, a_busy, b_valid, b_busy;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_tag, b_tag;
  logic [7:0]    a_drop;
  logic [1:0]    b_drop;
`ifdef TAP_SERIALIZER_PARITY_EN
  logic          a_parity, b_parity;
`endif

  always #5 clock = ~clock;

  tap_serializer #(.DATA_WIDTH(DW), .DROP_WIDTH(8)) u_dut_a (
    .clock(clock), .rst(rst), .sample(sample),
    .tap_1(tap_1), .tap_2(tap_2), .tap_4(tap_4), .tap_7(tap_7),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
    .out_tag(a_tag), .busy(a_busy), .drop_count(a_drop)
`ifdef TAP_SERIALIZER_PARITY_EN
    , .out_parity(a_parity)
`endif
  );

  tap_serializer #(.DATA_WIDTH(DW), .DROP_WIDTH(2)) u_dut_b (
    .clock(clock), .rst(rst), .sample(sample),
    .tap_1(tap_1), .tap_2(tap_2), .tap_4(tap_4), .tap_7(tap_7),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
    .out_tag(b_tag), .busy(b_busy), .drop_count(b_drop)
`ifdef TAP_SERIALIZER_PARITY_EN
    , .out_parity(b_parity)
`endif
  );

  typedef struct packed {
    logic [1:0]    tag;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    exp_drop_a;
  int    exp_drop_b;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic set_taps(input logic [DW-1:0] t1, input logic [DW-1:0] t2,
                          input logic [DW-1:0] t4, input logic [DW-1:0] t7);
    tap_1 = t1;
    tap_2 = t2;
    tap_4 = t4;
    tap_7 = t7;
  endtask

  // One clock cycle: drive, compare against the scoreboard head, then advance
  // the reference (pop on transfer, push four beats or count a drop on sample).
  task automatic cycle(input logic s, input logic r);
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_t;
    sample    = s;
    out_ready = r;
    @(negedge clock);
    exp_v = (sb.size() > 0);
    exp_d = exp_v ? sb[0].data : '0;
    exp_t = exp_v ? sb[0].tag  : 2'd0;
    check("a_valid", a_valid, exp_v);
    check("a_data",  a_data,  exp_d);
    check("a_tag",   a_tag,   exp_t);
    check("a_busy",  a_busy,  exp_v);
    check("b_valid", b_valid, exp_v);
    check("b_data",  b_data,  exp_d);
    check("b_tag",   b_tag,   exp_t);
    check("a_drop",  a_drop,  exp_drop_a);
    check("b_drop",  b_drop,  exp_drop_b);
`ifdef TAP_SERIALIZER_PARITY_EN
    check("a_parity", a_parity, exp_v & (^exp_d));
    check("b_parity", b_parity, exp_v & (^exp_d));
`endif
    if (r && (sb.size() > 0)) begin
      void'(sb.pop_front());
    end
    if (s) begin
      if (sb.size() == 0) begin
        sb.push_back('{tag: TAG_T1, data: tap_1});
        sb.push_back('{tag: TAG_T2, data: tap_2});
        sb.push_back('{tag: TAG_T4, data: tap_4});
        sb.push_back('{tag: TAG_T7, data: tap_7});
      end else begin
        if (exp_drop_a < 255) exp_drop_a++;
        if (exp_drop_b < 3)   exp_drop_b++;
      end
    end
    @(posedge clock);
    #1;
    // Taps wander after every edge; captured data must not follow them.
    set_taps(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  // Reset with sample and a busy frame active: reset must win.
  task automatic do_reset();
    rst       = 1'b1;
    sample    = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    rst    = 1'b0;
    sample = 1'b0;
    sb.delete();
    exp_drop_a = 0;
    exp_drop_b = 0;
    @(negedge clock);
    check("rst_valid", a_valid, 0);
    check("rst_data",  a_data,  0);
    check("rst_tag",   a_tag,   0);
    check("rst_busy",  a_busy,  0);
    check("rst_drop",  a_drop,  0);
    check("rst_bdrop", b_drop,  0);
`ifdef TAP_SERIALIZER_PARITY_EN
    check("rst_parity", a_parity, 0);
`endif
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    sample = 1'b0;
    out_ready = 1'b0;
    set_taps('0, '0, '0, '0);
    exp_drop_a = 0;
    exp_drop_b = 0;
    do_reset();

    // Basic frame with ready held high.
    set_taps(16'h0001, 16'h0002, 16'h0004, 16'h0007);
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1);

    // Backpressure for three cycles while tag 1 is presented.
    set_taps(16'h0001, 16'h0002, 16'h0004, 16'h0007);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);

    // Two samples during SEND are dropped; the frame is untouched.
    set_taps(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);
    check("drop_two", a_drop, 2);

    // Six more drops: the 2-bit counter pins at 3.
    set_taps(16'h0001, 16'h0002, 16'h0004, 16'h0007);
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b1);
    check("drop_sat2", b_drop, 3);

    // Sample coincident with the last beat: back-to-back frames.
    set_taps(16'h0001, 16'h0002, 16'h0004, 16'h0007);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    set_taps(16'hFFFF, 16'h00FF, 16'hFF00, 16'h0F0F);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);

    // Reset in the middle of a frame at idx=2, then a fresh frame.
    set_taps(16'hABCD, 16'h1234, 16'h5678, 16'h9ABC);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    do_reset();
    set_taps(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Long drop burst saturates the 8-bit counter.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0);
    end
    check("drop_sat8", a_drop, 255);

    // Drain, bounded.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1);
    end
    check("drained", a_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
